// File: rtl/chem_pulse_counter_pkg.sv
// Shared constants for the chemical-sensor pulse counter: channel/width
// defaults, snapshot field layout and FSM state encodings.
package chem_pulse_counter_pkg;

  localparam int NCH     = 8;
  localparam int CNT_W   = 12;
  localparam int WIN_W   = 16;
  localparam int FIELD_W = CNT_W + 1;
  localparam int OVF_BIT = CNT_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

endpackage

// File: rtl/chem_pulse_counter_if.sv
// Snapshot handshake bus between the pulse counter (master) and its
// consumer (slave).
interface chem_pulse_counter_if;
  import chem_pulse_counter_pkg::*;

  logic [NCH*FIELD_W-1:0] cnt_data;
  logic                   data_valid;
  logic                   data_ack;

  modport master (output cnt_data, output data_valid, input data_ack);
  modport slave  (input cnt_data, input data_valid, output data_ack);

endinterface

// File: rtl/chem_edge_cnt.sv
// One chem_out channel: 2-FF synchroniser, registered rising-edge detect and
// a saturating counter with a sticky overflow flag.
module chem_edge_cnt
  import chem_pulse_counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             clr,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] snap_cnt,
  output logic             snap_ovf
);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             prev_q, prev_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // snap_* already includes an edge detected this cycle, so a snapshot taken
  // now sees it even though the live counter is being cleared.
  always_comb begin
    s1_d     = pulse_in;
    s2_d     = s1_q;
    prev_d   = s2_q;
    rise_d   = s2_q & ~prev_q;
    snap_cnt = cnt_q;
    snap_ovf = ovf_q;
    if (rise_q && cnt_en) begin
      if (&cnt_q) snap_ovf = 1'b1;
      else        snap_cnt = cnt_q + CNT_W'(1);
    end
    cnt_d = clr ? '0   : snap_cnt;
    ovf_d = clr ? 1'b0 : snap_ovf;
  end

endmodule

// File: rtl/chem_pulse_counter.sv
// Gated pulse counter for the 8 chem_out lines: counts edges per window,
// snapshots {ovf, count} per channel and offers it over a valid/ack bus.
module chem_pulse_counter
  import chem_pulse_counter_pkg::*;
(
  input  logic                 clk_50M,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIN_W-1:0]     win_len,
  input  logic [NCH-1:0]       chem_out,
  chem_pulse_counter_if.master bus,
  output logic                 overrun,
  output logic                 busy
);

  state_e                 state_q, state_d;
  logic [WIN_W-1:0]       win_q, win_d, win_load;
  logic [NCH*FIELD_W-1:0] cnt_data_q, cnt_data_d, snap_word;
  logic                   data_valid_q, data_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   cnt_clr, cnt_en;
  logic [CNT_W-1:0]       snap_cnt [NCH];
  logic [NCH-1:0]         snap_ovf;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      chem_edge_cnt u_cnt (
        .clk      (clk_50M),
        .rst      (rst),
        .pulse_in (chem_out[gi]),
        .clr      (cnt_clr),
        .cnt_en   (cnt_en),
        .snap_cnt (snap_cnt[gi]),
        .snap_ovf (snap_ovf[gi])
      );
      assign snap_word[gi*FIELD_W +: FIELD_W] = {snap_ovf[gi], snap_cnt[gi]};
    end
  endgenerate

  // A zero window length behaves as one count cycle.
  assign win_load = (win_len == '0) ? '0 : win_len - WIN_W'(1);

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      win_q        <= '0;
      cnt_data_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      cnt_data_q   <= cnt_data_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_COUNT;
      ST_COUNT: begin
        if (!en)               state_d = ST_IDLE;
        else if (win_q == '0)  state_d = ST_LATCH;
      end
      ST_LATCH: state_d = ST_COUNT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q == ST_COUNT);
    cnt_clr      = (state_q != ST_COUNT);
    cnt_en       = (state_q != ST_IDLE);
    win_d        = win_q;
    cnt_data_d   = cnt_data_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
    case (state_q)
      ST_IDLE:  if (en) win_d = win_load;
      ST_COUNT: if (win_q != '0) win_d = win_q - WIN_W'(1);
      ST_LATCH: win_d = win_load;
      default:  win_d = '0;
    endcase
    // A new snapshot wins over an ack in the same cycle; the ack then
    // consumed the old word, so it is not an overrun.
    if (state_q == ST_LATCH) begin
      cnt_data_d   = snap_word;
      data_valid_d = 1'b1;
      if (data_valid_q && !bus.data_ack) overrun_d = 1'b1;
    end else if (bus.data_ack) begin
      data_valid_d = 1'b0;
    end
  end

  assign bus.cnt_data   = cnt_data_q;
  assign bus.data_valid = data_valid_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_chem_pulse_counter.sv
// Randomised bench for chem_pulse_counter: an edge-time reference model feeds
// a snapshot queue that a negedge monitor checks against the DUT.
module tb_chem_pulse_counter;
  import chem_pulse_counter_pkg::*;

  typedef logic [NCH*FIELD_W-1:0] word_t;

  logic             clk_50M = 1'b0;
  logic             rst     = 1'b1;
  logic             en      = 1'b0;
  logic [WIN_W-1:0] win_len = '0;
  logic [NCH-1:0]   chem_out = '0;
  logic             overrun;
  logic             busy;

  chem_pulse_counter_if bus();

  chem_pulse_counter dut (
    .clk_50M  (clk_50M),
    .rst      (rst),
    .en       (en),
    .win_len  (win_len),
    .chem_out (chem_out),
    .bus      (bus),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #10 clk_50M = ~clk_50M;

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic longint period(input logic [WIN_W-1:0] w);
    longint p;
    p = (w == '0) ? 64'd1 : longint'(w);
    return p + 1;
  endfunction

  // Reference model: an input rise sampled at edge k is counted at edge k+3;
  // a window opened at edge E snapshots at E+max(w,1)+1 and then repeats.
  word_t          exp_q[$];
  bit             m_active = 1'b0;
  bit             m_ovr    = 1'b0;
  bit             m_busy   = 1'b0;
  longint         m_edge   = 0;
  longint         m_latch  = 0;
  int             m_acc [NCH];
  bit             m_flag [NCH];
  logic [NCH-1:0] m_prev;
  logic [NCH-1:0] m_pipe [3];

  initial begin
    logic [NCH-1:0] inc;
    word_t          w;
    m_prev = '0;
    for (int i = 0; i < 3; i++) m_pipe[i] = '0;
    for (int c = 0; c < NCH; c++) begin m_acc[c] = 0; m_flag[c] = 1'b0; end
    forever begin
      @(posedge clk_50M or posedge rst);
      if (rst) begin
        m_active = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
        exp_q.delete();
        m_prev = '0;
        for (int i = 0; i < 3; i++) m_pipe[i] = '0;
        for (int c = 0; c < NCH; c++) begin m_acc[c] = 0; m_flag[c] = 1'b0; end
      end else begin
        m_edge++;
        inc       = m_pipe[2];
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = chem_out & ~m_prev;
        m_prev    = chem_out;
        if (m_active) begin
          for (int c = 0; c < NCH; c++)
            if (inc[c]) begin
              if (m_acc[c] == (1 << CNT_W) - 1) m_flag[c] = 1'b1;
              else m_acc[c]++;
            end
          if (m_edge == m_latch) begin
            for (int c = 0; c < NCH; c++)
              w[c*FIELD_W +: FIELD_W] = {m_flag[c], CNT_W'(m_acc[c])};
            if (exp_q.size() > 0) begin
              m_ovr = 1'b1;
              void'(exp_q.pop_front());
            end
            exp_q.push_back(w);
            for (int c = 0; c < NCH; c++) begin m_acc[c] = 0; m_flag[c] = 1'b0; end
            m_latch = m_edge + period(win_len);
          end else if (!en) begin
            m_active = 1'b0;
          end
        end else if (en) begin
          m_active = 1'b1;
          for (int c = 0; c < NCH; c++) begin m_acc[c] = 0; m_flag[c] = 1'b0; end
          m_latch = m_edge + period(win_len);
        end
        m_busy = m_active && (m_latch != m_edge + 1);
      end
    end
  end

  // Monitor: status every cycle, snapshot contents whenever the consumer takes one.
  initial begin
    forever begin
      @(negedge clk_50M);
      check("data_valid", 128'(bus.data_valid), 128'(exp_q.size() > 0));
      check("overrun", 128'(overrun), 128'(m_ovr));
      check("busy", 128'(busy), 128'(m_busy));
      if (exp_q.size() > 0 && bus.data_ack) begin
        n_txn++;
        $display("txn %0d t=%0t cnt_data=%h overrun=%0b", n_txn, $time, bus.cnt_data, overrun);
        check("cnt_data", 128'(bus.cnt_data), 128'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end

  // Stimulus: each active channel toggles after a random (or fixed 2-cycle) hold.
  logic [NCH-1:0] act_mask = '0;
  bit             fixed    = 1'b0;
  int             ack_mode = 0;
  int             dur [NCH];

  task automatic step();
    @(posedge clk_50M);
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (!act_mask[c]) begin
        chem_out[c] = 1'b0;
        dur[c] = 2;
      end else if (dur[c] <= 1) begin
        chem_out[c] = ~chem_out[c];
        dur[c] = fixed ? 2 : int'($urandom_range(2, 5));
      end else begin
        dur[c]--;
      end
    end
    case (ack_mode)
      0:       bus.data_ack = 1'b0;
      1:       bus.data_ack = 1'($urandom_range(0, 1));
      default: bus.data_ack = 1'b1;
    endcase
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    int waited;
    bus.data_ack = 1'b0;
    for (int c = 0; c < NCH; c++) dur[c] = 2;
    run(3);
    check("reset_cnt_data", 128'(bus.cnt_data), 128'(0));
    check("reset_valid", 128'(bus.data_valid), 128'(0));
    rst = 1'b0;

    // Basic windows on channels 0 and 3.
    win_len = 16'd100; en = 1'b1; act_mask = 8'h09; ack_mode = 1;
    run(420);

    // All channels, random short windows; win_len changes mid-window.
    for (int i = 0; i < 6; i++) begin
      win_len  = WIN_W'($urandom_range(0, 30));
      act_mask = NCH'($urandom);
      run(int'($urandom_range(50, 200)));
    end

    // Saturation on channel 5, then an empty window.
    en = 1'b0; act_mask = '0; ack_mode = 2;
    run(6);
    win_len = 16'd16600; en = 1'b1; act_mask = 8'h20; fixed = 1'b1;
    run(16450);
    act_mask = '0;
    run(16601 * 2 + 10);
    fixed = 1'b0;

    // Unacked windows cause overrun; then resume acking.
    win_len = 16'd20; act_mask = NCH'($urandom); ack_mode = 0;
    run(80);
    ack_mode = 1;
    run(100);

    // Abort mid-window, then re-enable.
    en = 1'b0; run(5);
    win_len = 16'd50; en = 1'b1; act_mask = 8'h04;
    run(20);
    en = 1'b0; run(10);
    en = 1'b1; run(120);

    // Minimum window with one edge every 4 cycles.
    win_len = '0; act_mask = 8'h01; fixed = 1'b1; ack_mode = 2;
    run(40);
    fixed = 1'b0;

    // Random enable, window and ack traffic.
    for (int i = 0; i < 25; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      win_len  = WIN_W'($urandom_range(0, 8));
      act_mask = NCH'($urandom);
      ack_mode = int'($urandom_range(0, 2));
      run(int'($urandom_range(5, 40)));
    end

    // Asynchronous reset while counting with a snapshot pending.
    en = 1'b1; win_len = 16'd10; ack_mode = 0; act_mask = 8'hFF;
    waited = 0;
    while (!bus.data_valid && waited < 60) begin
      step();
      waited++;
    end
    if (!bus.data_valid) begin
      n_checks++;
      $display("FAIL wait_valid: data_valid=0 after %0d cycles, required 1", waited);
    end
    @(negedge clk_50M);
    #2;
    rst = 1'b1;
    #1;
    check("async_cnt_data", 128'(bus.cnt_data), 128'(0));
    check("async_valid", 128'(bus.data_valid), 128'(0));
    check("async_overrun", 128'(overrun), 128'(0));
    check("async_busy", 128'(busy), 128'(0));
    run(2);
    rst = 1'b0;
    ack_mode = 1;
    run(60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
